// File: rtl/insn_buffer_pkg.sv
// Shared types for the instruction parcel buffer.
//
// insn_buffer_entry_t : one 16-bit parcel and the tags that travel with it
//                       (PC, ITLB fault, pending interrupt and its cause).
// PARCEL_WIDTH        : width of one instruction parcel.
// IrqCodeWidth        : width of the interrupt cause code carried per parcel.
// is_compressed       : RISC-V length decode of a lowest parcel. Any encoding
//                       whose two low bits are not 2'b11 is a 16-bit instruction.
package insn_buffer_pkg;

  localparam int unsigned PARCEL_WIDTH = 16;
  localparam int unsigned IrqCodeWidth = 4;

  typedef struct packed {
    logic [31:0]             pc;
    logic [PARCEL_WIDTH-1:0] parcel;
    logic                    fault;
    logic                    irq_valid;
    logic [IrqCodeWidth-1:0] irq_code;
  } insn_buffer_entry_t;

  function automatic logic is_compressed(input logic [PARCEL_WIDTH-1:0] parcel);
    return parcel[1:0] != 2'b11;
  endfunction

endpackage

// File: rtl/insn_buffer_storage.sv
// Parcel storage for insn_buffer.
//
// DEPTH-entry register array with two write ports and two combinational read
// ports. The contents need no reset: the owner tracks validity with its own
// pointers and count.
//
// Ports:
//   clk_i                   clock
//   wr0_en_i/addr_i/data_i  first write port
//   wr1_en_i/addr_i/data_i  second write port (never the same address as port 0)
//   rd0_addr_i, rd0_data_o  read port for the head entry
//   rd1_addr_i, rd1_data_o  read port for the entry after the head
module insn_buffer_storage
  import insn_buffer_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  localparam int unsigned AW   = $clog2(DEPTH)
) (
  input  logic               clk_i,
  input  logic               wr0_en_i,
  input  logic [AW-1:0]      wr0_addr_i,
  input  insn_buffer_entry_t wr0_data_i,
  input  logic               wr1_en_i,
  input  logic [AW-1:0]      wr1_addr_i,
  input  insn_buffer_entry_t wr1_data_i,
  input  logic [AW-1:0]      rd0_addr_i,
  output insn_buffer_entry_t rd0_data_o,
  input  logic [AW-1:0]      rd1_addr_i,
  output insn_buffer_entry_t rd1_data_o
);

  insn_buffer_entry_t mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr0_en_i) begin
      mem_q[wr0_addr_i] <= wr0_data_i;
    end
    if (wr1_en_i) begin
      mem_q[wr1_addr_i] <= wr1_data_i;
    end
  end

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/insn_buffer.sv
// Instruction parcel buffer between the fetch pipe and decode.
//
// Accepts up to two 16-bit parcels per cycle (low, then high) and presents one
// reassembled instruction per cycle: a single parcel when compressed (or when
// the head parcel faulted), otherwise the head parcel and the one after it.
// Reports free space from the registered count so fetch can stall early.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   flush                    drop all entries; wins over same-cycle writes/reads
//   write_low*, write_high*  parcel enqueue ports with PC/fault/irq tags
//   writable_entry_count     DEPTH minus the registered count
//   read_valid, read_ready   instruction handshake to decode
//   read_pc, read_insn       head PC and instruction (upper half zero if 16-bit)
//   read_compressed          instruction occupies one parcel
//   read_fault               fault on any parcel consumed by this instruction
//   read_irq_valid/code      interrupt tag of the head parcel
module insn_buffer
  import insn_buffer_pkg::*;
#(
  parameter int unsigned DEPTH          = 8,
  // Must equal IrqCodeWidth: the stored entry type carries that many bits.
  parameter int unsigned IRQ_CODE_WIDTH = IrqCodeWidth,
  localparam int unsigned AW            = $clog2(DEPTH),
  localparam int unsigned CW            = $clog2(DEPTH + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush,

  input  logic                      write_low,
  input  logic [31:0]               write_low_pc,
  input  logic [PARCEL_WIDTH-1:0]   write_low_parcel,
  input  logic                      write_low_fault,
  input  logic                      write_low_irq_valid,
  input  logic [IRQ_CODE_WIDTH-1:0] write_low_irq_code,

  input  logic                      write_high,
  input  logic [31:0]               write_high_pc,
  input  logic [PARCEL_WIDTH-1:0]   write_high_parcel,
  input  logic                      write_high_fault,
  input  logic                      write_high_irq_valid,
  input  logic [IRQ_CODE_WIDTH-1:0] write_high_irq_code,

  output logic [CW-1:0]             writable_entry_count,

  output logic                      read_valid,
  input  logic                      read_ready,
  output logic [31:0]               read_pc,
  output logic [31:0]               read_insn,
  output logic                      read_compressed,
  output logic                      read_fault,
  output logic                      read_irq_valid,
  output logic [IRQ_CODE_WIDTH-1:0] read_irq_code
);

  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  insn_buffer_entry_t low_entry, high_entry;
  insn_buffer_entry_t wr0_data;
  logic               wr0_en, wr1_en;
  logic [AW-1:0]      tail_plus1;
  logic [AW-1:0]      head_plus1;

  insn_buffer_entry_t head_entry, next_entry;
  logic               head_single;
  logic               pop;
  logic [1:0]         pop_n;
  logic [1:0]         req_n;
  logic [1:0]         wr_n;
  logic               overflow;

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  always_comb begin
    low_entry           = '0;
    low_entry.pc        = write_low_pc;
    low_entry.parcel    = write_low_parcel;
    low_entry.fault     = write_low_fault;
    low_entry.irq_valid = write_low_irq_valid;
    low_entry.irq_code  = write_low_irq_code;

    high_entry           = '0;
    high_entry.pc        = write_high_pc;
    high_entry.parcel    = write_high_parcel;
    high_entry.fault     = write_high_fault;
    high_entry.irq_valid = write_high_irq_valid;
    high_entry.irq_code  = write_high_irq_code;
  end

  assign req_n = {1'b0, write_low} + {1'b0, write_high};

  // A slot freed by a same-cycle pop may be refilled, so a write at full is
  // accepted alongside a read. Anything beyond that is dropped whole.
  always_comb begin
    logic [CW:0] room;
    room     = {1'b0, writable_entry_count} + (CW + 1)'(pop_n);
    overflow = (CW + 1)'(req_n) > room;
  end

  assign wr_n = overflow ? 2'd0 : req_n;

  // Port 0 always takes the first parcel at tail (low if present, else high);
  // port 1 only ever carries the high parcel of a pair.
  assign tail_plus1 = tail_q + AW'(1);
  assign wr0_en     = !flush && (wr_n != 2'd0);
  assign wr1_en     = !flush && (wr_n == 2'd2);
  assign wr0_data   = write_low ? low_entry : high_entry;

  // ---------------------------------------------------------------------------
  // Storage
  // ---------------------------------------------------------------------------
  assign head_plus1 = head_q + AW'(1);

  insn_buffer_storage #(
    .DEPTH(DEPTH)
  ) u_storage (
    .clk_i      (clk),
    .wr0_en_i   (wr0_en),
    .wr0_addr_i (tail_q),
    .wr0_data_i (wr0_data),
    .wr1_en_i   (wr1_en),
    .wr1_addr_i (tail_plus1),
    .wr1_data_i (high_entry),
    .rd0_addr_i (head_q),
    .rd0_data_o (head_entry),
    .rd1_addr_i (head_plus1),
    .rd1_data_o (next_entry)
  );

  // ---------------------------------------------------------------------------
  // Read side: classify the head from registered entries only
  // ---------------------------------------------------------------------------
  // A faulting head goes out on its own so decode can raise the fault even if
  // the upper half was never fetched.
  assign head_single = is_compressed(head_entry.parcel) || head_entry.fault;

  assign writable_entry_count = CW'(DEPTH) - count_q;

  assign read_valid = ((count_q != '0) && head_single) || (count_q >= CW'(2));

  always_comb begin
    read_pc         = head_entry.pc;
    read_irq_valid  = head_entry.irq_valid;
    read_irq_code   = head_entry.irq_code;
    read_compressed = head_single;
    if (head_single) begin
      read_insn  = {{(32 - PARCEL_WIDTH){1'b0}}, head_entry.parcel};
      read_fault = head_entry.fault;
    end else begin
      read_insn  = {next_entry.parcel, head_entry.parcel};
      read_fault = head_entry.fault | next_entry.fault;
    end
  end

  assign pop   = read_valid && read_ready;
  assign pop_n = !pop ? 2'd0 : (head_single ? 2'd1 : 2'd2);

  // ---------------------------------------------------------------------------
  // Pointer and count state
  // ---------------------------------------------------------------------------
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      head_d  = head_q + AW'(pop_n);
      tail_d  = tail_q + AW'(wr_n);
      count_d = count_q + CW'(wr_n) - CW'(pop_n);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // The fetch pipe promises never to exceed the available space.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst || flush) !overflow)
    else $error("insn_buffer: write overflow, parcels dropped");

endmodule

// File: doc/insn_buffer.md
Name: insn_buffer

Overview:
- Parcel FIFO between the fetch pipe's instruction-traverse stage and decode.
- Accepts up to two 16-bit parcels per cycle (low, then high), each tagged with PC, fault and interrupt info.
- Presents one reassembled instruction per cycle to decode, either compressed (1 parcel) or 32-bit (2 parcels).
- Reports free space back to the fetch pipe, which stalls and refetches when fewer than 2 entries are free.

Parameters:
DEPTH, 8, number of 16-bit parcel entries; power of 2, at least 4
IRQ_CODE_WIDTH, 4, width of the interrupt cause code carried per parcel

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  discard all entries (redirect / pipeline flush)
write_low  in  1  enqueue low parcel
write_low_pc  in  32  PC of low parcel
write_low_parcel  in  16  low parcel bits
write_low_fault  in  1  ITLB fault on low parcel
write_low_irq_valid  in  1  pending interrupt tag
write_low_irq_code  in  IRQ_CODE_WIDTH  interrupt cause
write_high, write_high_pc, write_high_parcel, write_high_fault, write_high_irq_valid, write_high_irq_code  in  1/32/16/1/1/IRQ_CODE_WIDTH  same fields for the high parcel
writable_entry_count  out  $clog2(DEPTH+1)  free entries
read_valid  out  1  an instruction is available
read_ready  in  1  decode consumes it this cycle
read_pc  out  32  PC of the head parcel
read_insn  out  32  instruction; upper 16 bits are zero when compressed
read_compressed  out  1  instruction is 16-bit
read_fault  out  1  fault on any consumed parcel
read_irq_valid  out  1  interrupt tag of the head parcel
read_irq_code  out  IRQ_CODE_WIDTH  cause of the head parcel

Behaviour:
- State: head pointer, tail pointer (log2 DEPTH bits, wrap modulo DEPTH), count (0..DEPTH), entry array.
- Reset or flush at a clock edge: head=tail=count=0. Entry contents are don't-care. Flush overrides any same-cycle write or read.
- Outputs while count=0: read_valid=0, writable_entry_count=DEPTH. Other read_* outputs are don't-care whenever read_valid=0.
- writable_entry_count = DEPTH - count, derived combinationally from registered count only. It does not reflect same-cycle reads or writes.
- Write ordering:
  - Low parcel is written at tail, high parcel at tail+1 when both are asserted.
  - Only high asserted: high is written at tail.
  - Tail advances by the number of parcels written.
- Overflow: the writer guarantees the number of writes ≤ writable_entry_count. A violation fires an assertion, and the offending writes are dropped.
- Head classification uses the registered entries; there is no write-to-read bypass, so read latency is at least 1 cycle after write.
  - Compressed iff parcel[1:0] != 2'b11.
  - Fault head (fault=1) is treated as a single-parcel instruction regardless of bits. This prevents deadlock when the high half was never fetched.
  - read_valid = (count≥1 && (compressed || fault)) || (count≥2).
- 32-bit instruction: read_insn = {entry[head+1].parcel, entry[head].parcel}; read_fault = OR of both faults. read_pc and irq fields come from the head.
- Pop happens when read_valid && read_ready. Head advances by 1 (compressed or fault head) or 2, wrapping.
- count_next = count + writes - pops. Simultaneous read and write is legal, including at full (count=DEPTH) and at empty.
- A 32-bit instruction whose second parcel sits at index 0 after wrap reassembles correctly.

Decomposition:
- The RafiTypes package holds:
  - insn_buffer_entry_t struct (pc, parcel, fault, irq_valid, irq_code);
  - PARCEL_WIDTH=16;
  - the is_compressed helper function.
- The IRQ code width constant lives in the same package.
- One sub-module: insn_buffer_storage, a DEPTH-entry register array with 2 write ports and 2 combinational read ports (head, head+1).
- Pointer and count logic and read classification stay in insn_buffer.

Test Plan:
- Reset, then write low=0x0513 (pc 0x100) and high=0x0000 (pc 0x102); next cycle -> read_valid=1, read_insn=0x00000513, read_compressed=0, read_pc=0x100, writable=6.
- Write low=0x4501 and high=0x4505 (pcs 0x200/0x202), read_ready=1 -> two consecutive pops of compressed 0x00004501 then 0x00004505, pcs 0x200 then 0x202, count returns to 0.
- Head is the lower half of a 32-bit instruction (0x0093) with count=1 -> read_valid=0. Write the upper parcel -> read_valid=1 next cycle.
- Fill to 8 with continuous read_ready=0, then write and read in the same cycle -> count stays 8. Check correct reassembly across wrap (head=7, second parcel at index 0).
- Fault parcel 0x0003 at head, count=1 -> read_valid=1, read_fault=1, pops 1.
- Fill with 6 entries, then flush with a simultaneous write and read_ready -> next cycle count=0, writable=8, read_valid=0.
